// File: rtl/cmd_display_scheduler.sv
// cmd_display_scheduler
// Keeps the last NUM_DIGITS command characters (slot 0 = newest) and shows
// each one on its own 7-segment digit. A single shared, registered decoder
// (1 clk latency, active-low segments) is time-shared: every accepted command
// shifts the buffer and triggers a rescan of all slots through the decoder.
//
// Command handshake: a character transfers on a rising clk edge where
// cmd_valid && cmd_ready are both high. cmd_ready depends only on the hold
// counter, clear and reset (never on cmd_valid). The source may hold
// cmd_valid and cmd_char stable for as long as it likes; nothing transfers
// while cmd_ready is low.
module cmd_display_scheduler #(
  parameter int NUM_DIGITS  = 4,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_char,
  input  logic                    clear,
  output logic [7:0]              dec_char,
  input  logic [6:0]              dec_seg,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    sweep_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
  localparam logic [6:0]       BLANK     = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Pipeline tag travelling alongside a character through the decoder.
  typedef struct packed {
    logic             valid;
    logic             slot_valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  flush_q;
  logic                  issue;
  logic                  flush_last;
  logic                  accept;
  logic [7:0]            char_buf [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] slot_valid;
  logic [HC_W-1:0]       hold_cnt;
  tag_t                  tag1_q, tag2_q;

  assign cmd_ready = (hold_cnt == '0) && !clear && !reset;
  assign accept    = cmd_valid && cmd_ready;

  // Next-state and per-edge control for the sweep FSM; an accept restarts it.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    flush_last = 1'b0;
    case (state_q)
      IDLE: state_d = IDLE;
      SCAN: begin
        issue = 1'b1;
        if (idx_q == LAST_IDX) state_d = FLUSH;
      end
      FLUSH: begin
        if (flush_q) begin
          flush_last = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d    = SCAN;
      issue      = 1'b0;
      flush_last = 1'b0;
    end
  end

  // FSM state, scan index and flush-phase register.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= IDLE;
      idx_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= '0;
      end else if (issue) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
      flush_q <= (state_q == FLUSH) && !flush_q && !accept;
    end
  end

  // Character buffer, hold timer, decoder feed and segment capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_DIGITS; k++) char_buf[k] <= 8'd0;
      slot_valid <= '0;
      hex_out    <= {NUM_DIGITS{BLANK}};
      dec_char   <= 8'd0;
      sweep_done <= 1'b0;
      hold_cnt   <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
    end else if (clear) begin
      slot_valid <= '0;
      hex_out    <= {NUM_DIGITS{BLANK}};
      sweep_done <= 1'b0;
      hold_cnt   <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
    end else if (accept) begin
      // Shift everything one slot older; in-flight decodes are dropped so a
      // pre-shift index can never land on the wrong digit.
      for (int k = NUM_DIGITS - 1; k > 0; k--) char_buf[k] <= char_buf[k-1];
      char_buf[0] <= cmd_char;
      slot_valid  <= {slot_valid[NUM_DIGITS-2:0], 1'b1};
      hex_out     <= {hex_out[7*NUM_DIGITS-8:0], BLANK};
      hold_cnt    <= HOLD_LOAD;
      sweep_done  <= 1'b0;
      tag1_q      <= '0;
      tag2_q      <= '0;
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HC_W'(1);
      sweep_done <= flush_last;
      if (issue) begin
        dec_char <= char_buf[idx_q];
        tag1_q   <= '{valid: 1'b1, slot_valid: slot_valid[idx_q], idx: idx_q};
      end else begin
        tag1_q <= '0;
      end
      tag2_q <= tag1_q;
      if (tag2_q.valid) begin
        hex_out[7*int'(tag2_q.idx) +: 7] <= tag2_q.slot_valid ? dec_seg : BLANK;
      end
    end
  end

endmodule

// File: tb/tb_cmd_display_scheduler.sv
// Bench for cmd_display_scheduler: two instances (HOLD_CYCLES=1 and 10),
// each with a registered active-low decoder model, checked against a
// queue-of-characters reference model.
module tb_cmd_display_scheduler;

  localparam int N  = 4;
  localparam int HW = 7 * N;
  localparam logic [HW-1:0] ALL_BLANK = {N{7'h7F}};

  int checks   = 0;
  int failures = 0;

  // Clock/reset block
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: HOLD_CYCLES = 1
  logic          cmd_valid_a = 1'b0;
  logic          cmd_ready_a;
  logic [7:0]    cmd_char_a  = 8'd0;
  logic          clear_a     = 1'b0;
  logic [7:0]    dec_char_a;
  logic [6:0]    dec_seg_a   = 7'h7F;
  logic [HW-1:0] hex_a;
  logic          sweep_done_a;

  // Instance B: HOLD_CYCLES = 10
  logic          cmd_valid_b = 1'b0;
  logic          cmd_ready_b;
  logic [7:0]    cmd_char_b  = 8'd0;
  logic          clear_b     = 1'b0;
  logic [7:0]    dec_char_b;
  logic [6:0]    dec_seg_b   = 7'h7F;
  logic [HW-1:0] hex_b;
  logic          sweep_done_b;

  cmd_display_scheduler #(.NUM_DIGITS(N), .HOLD_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_char(cmd_char_a), .clear(clear_a), .dec_char(dec_char_a),
    .dec_seg(dec_seg_a), .hex_out(hex_a), .sweep_done(sweep_done_a)
  );

  cmd_display_scheduler #(.NUM_DIGITS(N), .HOLD_CYCLES(10)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_char(cmd_char_b), .clear(clear_b), .dec_char(dec_char_b),
    .dec_seg(dec_seg_b), .hex_out(hex_b), .sweep_done(sweep_done_b)
  );

  // Board decoder: [6:0] = segments a..g, active low.
  function automatic logic [6:0] seg_of(input logic [7:0] c);
    case (c)
      8'd0:    return 7'h01;
      8'd1:    return 7'h4F;
      8'd2:    return 7'h12;
      8'd3:    return 7'h06;
      8'd4:    return 7'h4C;
      8'd5:    return 7'h24;
      8'd6:    return 7'h20;
      8'd7:    return 7'h0F;
      8'd8:    return 7'h00;
      8'd9:    return 7'h04;
      8'd102:  return 7'h38;  // f
      8'd114:  return 7'h7A;  // r
      8'd108:  return 7'h71;  // l
      default: return 7'h30;  // E
    endcase
  endfunction

  always @(posedge clk) begin
    dec_seg_a <= seg_of(dec_char_a);
    dec_seg_b <= seg_of(dec_char_b);
  end

  // Reference model: newest character first, at most N kept.
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  function automatic logic [HW-1:0] model_hex(input bit use_b);
    logic [HW-1:0] h;
    h = ALL_BLANK;
    for (int k = 0; k < N; k++) begin
      if (!use_b && k < exp_a.size()) h[7*k +: 7] = seg_of(exp_a[k]);
      if (use_b && k < exp_b.size()) h[7*k +: 7] = seg_of(exp_b[k]);
    end
    return h;
  endfunction

  task automatic push_a(input logic [7:0] c);
    exp_a.push_front(c);
    if (exp_a.size() > N) exp_a.delete(N);
  endtask

  task automatic push_b(input logic [7:0] c);
    exp_b.push_front(c);
    if (exp_b.size() > N) exp_b.delete(N);
  endtask

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 4))
      0:       return 8'($urandom_range(0, 9));
      1:       return 8'd102;
      2:       return 8'd114;
      3:       return 8'd108;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Driver tasks: called just after a negedge; return just after the
  // negedge that follows the accepting posedge.
  task automatic accept_a(input logic [7:0] c, output bit ok);
    int n;
    n = 0;
    cmd_char_a  = c;
    cmd_valid_a = 1'b1;
    #1;
    while (!cmd_ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready_a;
    @(negedge clk);
    cmd_valid_a = 1'b0;
  endtask

  task automatic accept_b(input logic [7:0] c, output bit ok);
    int n;
    n = 0;
    cmd_char_b  = c;
    cmd_valid_b = 1'b1;
    #1;
    while (!cmd_ready_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready_b;
    @(negedge clk);
    cmd_valid_b = 1'b0;
  endtask

  task automatic wait_done_a(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = sweep_done_a;
      n++;
    end
  endtask

  task automatic wait_done_b(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 60) begin
      @(negedge clk);
      ok = sweep_done_b;
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready_a !== 1'b0) begin failures++; $display("FAIL rst_ready_a got=%b exp=0", cmd_ready_a); end
    checks++; if (hex_a !== ALL_BLANK) begin failures++; $display("FAIL rst_hex_a got=%h exp=%h", hex_a, ALL_BLANK); end
    checks++; if (dec_char_a !== 8'd0) begin failures++; $display("FAIL rst_dec_char got=%h exp=00", dec_char_a); end
    checks++; if (sweep_done_a !== 1'b0) begin failures++; $display("FAIL rst_sweep_done got=%b exp=0", sweep_done_a); end
    checks++; if (hex_b !== ALL_BLANK) begin failures++; $display("FAIL rst_hex_b got=%h exp=%h", hex_b, ALL_BLANK); end
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready_a !== 1'b1) begin failures++; $display("FAIL rel_ready_a got=%b exp=1", cmd_ready_a); end
    checks++; if (cmd_ready_b !== 1'b1) begin failures++; $display("FAIL rel_ready_b got=%b exp=1", cmd_ready_b); end
    @(negedge clk);
    checks++; if (hex_a !== ALL_BLANK) begin failures++; $display("FAIL rel_hex_a got=%h exp=%h", hex_a, ALL_BLANK); end
  endtask

  task automatic test_first_command();
    bit ok;
    accept_a(8'd102, ok);
    push_a(8'd102);
    checks++; if (!ok) begin failures++; $display("FAIL first_accept got=timeout exp=accept"); end
    checks++; if (hex_a !== ALL_BLANK) begin failures++; $display("FAIL first_hex_A got=%h exp=%h", hex_a, ALL_BLANK); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (dec_char_a !== 8'd102) begin failures++; $display("FAIL first_dec_char got=%h exp=66", dec_char_a); end
      end
      if (k == 3) begin
        checks++; if (hex_a !== 28'hFFFFFB8) begin failures++; $display("FAIL first_hex_A3 got=%h exp=FFFFFB8", hex_a); end
      end
      checks++;
      if (sweep_done_a !== (k == 6)) begin
        failures++; $display("FAIL first_sweep_done k=%0d got=%b exp=%b", k, sweep_done_a, (k == 6));
      end
    end
  endtask

  task automatic test_sequence();
    bit ok, done;
    logic [7:0] seq [3];
    seq[0] = 8'd114; seq[1] = 8'd3; seq[2] = 8'd120;
    for (int i = 0; i < 3; i++) begin
      accept_a(seq[i], ok);
      push_a(seq[i]);
      wait_done_a(done);
      checks++; if (!(ok && done)) begin failures++; $display("FAIL seq_handshake i=%0d got=%b%b exp=11", i, ok, done); end
      checks++; if (hex_a !== model_hex(0)) begin failures++; $display("FAIL seq_hex i=%0d got=%h exp=%h", i, hex_a, model_hex(0)); end
    end
    checks++; if (hex_a[6:0] !== 7'h30) begin failures++; $display("FAIL seq_slot0 got=%h exp=30", hex_a[6:0]); end
    checks++; if (hex_a[13:7] !== 7'h06) begin failures++; $display("FAIL seq_slot1 got=%h exp=06", hex_a[13:7]); end
    checks++; if (hex_a[20:14] !== 7'h7A) begin failures++; $display("FAIL seq_slot2 got=%h exp=7A", hex_a[20:14]); end
    checks++; if (hex_a[27:21] !== 7'h38) begin failures++; $display("FAIL seq_slot3 got=%h exp=38", hex_a[27:21]); end
    accept_a(8'd9, ok);
    push_a(8'd9);
    wait_done_a(done);
    checks++; if (!(ok && done)) begin failures++; $display("FAIL seq9_handshake got=%b%b exp=11", ok, done); end
    checks++; if (hex_a[27:21] !== 7'h7A) begin failures++; $display("FAIL seq9_slot3 got=%h exp=7A", hex_a[27:21]); end
    checks++; if (hex_a[6:0] !== 7'h04) begin failures++; $display("FAIL seq9_slot0 got=%h exp=04", hex_a[6:0]); end
    checks++; if (hex_a !== model_hex(0)) begin failures++; $display("FAIL seq9_hex got=%h exp=%h", hex_a, model_hex(0)); end
  endtask

  task automatic test_random();
    bit ok, done;
    logic [7:0] c;
    logic [HW-1:0] prev;
    for (int i = 0; i < 8; i++) begin
      c = rand_char();
      prev = model_hex(0);
      accept_a(c, ok);
      push_a(c);
      checks++; if (hex_a !== {prev[HW-8:0], 7'h7F}) begin failures++; $display("FAIL rand_shift i=%0d got=%h exp=%h", i, hex_a, {prev[HW-8:0], 7'h7F}); end
      wait_done_a(done);
      checks++; if (!(ok && done)) begin failures++; $display("FAIL rand_handshake i=%0d got=%b%b exp=11", i, ok, done); end
      checks++; if (hex_a !== model_hex(0)) begin failures++; $display("FAIL rand_hex i=%0d got=%h exp=%h", i, hex_a, model_hex(0)); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int n_done;
    logic [7:0] c1, c2;
    c1 = rand_char();
    c2 = 8'($urandom_range(0, 9));
    accept_a(c1, ok1);
    push_a(c1);
    @(negedge clk);
    checks++; if (sweep_done_a !== 1'b0) begin failures++; $display("FAIL b2b_gap_done got=%b exp=0", sweep_done_a); end
    accept_a(c2, ok2);
    push_a(c2);
    checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL b2b_accept got=%b%b exp=11", ok1, ok2); end
    n_done = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (sweep_done_a) n_done++;
      checks++;
      if (sweep_done_a !== (k == 6)) begin
        failures++; $display("FAIL b2b_sweep_done k=%0d got=%b exp=%b", k, sweep_done_a, (k == 6));
      end
    end
    checks++; if (n_done != 1) begin failures++; $display("FAIL b2b_done_count got=%0d exp=1", n_done); end
    checks++; if (hex_a !== model_hex(0)) begin failures++; $display("FAIL b2b_hex got=%h exp=%h", hex_a, model_hex(0)); end
  endtask

  task automatic test_hold();
    bit ok, done;
    logic [7:0] c2;
    c2 = 8'($urandom_range(0, 9));
    accept_b(8'd108, ok);
    push_b(8'd108);
    checks++; if (!ok) begin failures++; $display("FAIL hold_accept got=timeout exp=accept"); end
    cmd_char_b  = c2;
    cmd_valid_b = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      checks++;
      if (cmd_ready_b !== (k == 9)) begin
        failures++; $display("FAIL hold_ready k=%0d got=%b exp=%b", k, cmd_ready_b, (k == 9));
      end
      if (k < 9) @(negedge clk);
    end
    @(negedge clk);
    cmd_valid_b = 1'b0;
    push_b(c2);
    checks++; if (cmd_ready_b !== 1'b0) begin failures++; $display("FAIL hold_reload got=%b exp=0", cmd_ready_b); end
    wait_done_b(done);
    checks++; if (!done) begin failures++; $display("FAIL hold_sweep got=timeout exp=done"); end
    checks++; if (hex_b !== model_hex(1)) begin failures++; $display("FAIL hold_hex got=%h exp=%h", hex_b, model_hex(1)); end
  endtask

  task automatic test_clear();
    bit ok, done;
    int n_done, n_change;
    logic [7:0] c;
    accept_a(rand_char(), ok);
    @(negedge clk);
    clear_a     = 1'b1;
    cmd_valid_a = 1'b1;
    cmd_char_a  = rand_char();
    #1;
    checks++; if (cmd_ready_a !== 1'b0) begin failures++; $display("FAIL clr_ready got=%b exp=0", cmd_ready_a); end
    @(negedge clk);
    clear_a     = 1'b0;
    cmd_valid_a = 1'b0;
    exp_a.delete();
    checks++; if (hex_a !== ALL_BLANK) begin failures++; $display("FAIL clr_hex got=%h exp=%h", hex_a, ALL_BLANK); end
    n_done = 0;
    n_change = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sweep_done_a) n_done++;
      if (hex_a !== ALL_BLANK) n_change++;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL clr_no_done got=%0d exp=0", n_done); end
    checks++; if (n_change != 0) begin failures++; $display("FAIL clr_hex_stable got=%0d exp=0", n_change); end
    c = rand_char();
    accept_a(c, ok);
    push_a(c);
    wait_done_a(done);
    checks++; if (!(ok && done)) begin failures++; $display("FAIL clr_after_handshake got=%b%b exp=11", ok, done); end
    checks++; if (hex_a[HW-1:7] !== ALL_BLANK[HW-1:7]) begin failures++; $display("FAIL clr_after_others got=%h exp=%h", hex_a[HW-1:7], ALL_BLANK[HW-1:7]); end
    checks++; if (hex_a !== model_hex(0)) begin failures++; $display("FAIL clr_after_hex got=%h exp=%h", hex_a, model_hex(0)); end
  endtask

  task automatic test_reset_mid_sweep();
    bit ok;
    int n_done, n_change;
    accept_a(rand_char(), ok);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (hex_a !== ALL_BLANK) begin failures++; $display("FAIL rstmid_hex got=%h exp=%h", hex_a, ALL_BLANK); end
    checks++; if (sweep_done_a !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", sweep_done_a); end
    checks++; if (cmd_ready_a !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", cmd_ready_a); end
    reset = 1'b0;
    exp_a.delete();
    exp_b.delete();
    n_done = 0;
    n_change = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sweep_done_a) n_done++;
      if (hex_a !== ALL_BLANK) n_change++;
    end
    checks++; if (n_done != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", n_done); end
    checks++; if (n_change != 0) begin failures++; $display("FAIL rstmid_no_write got=%0d exp=0", n_change); end
  endtask

  initial begin
    test_reset();
    test_first_command();
    test_sequence();
    test_random();
    test_back_to_back();
    test_hold();
    test_clear();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
